// File: rtl/lin_rx_char_deframer_pkg.sv
// Shared LIN receive definitions: well-known characters and deframer FSM states.
package lin_rx_char_deframer_pkg;

  // Characters as seen on data_out: {stop, data[7:0], start}
  localparam logic [9:0] LIN_BREAK_CHAR = 10'h000;
  localparam logic [9:0] LIN_DELIM_CHAR = 10'h200;
  localparam logic [9:0] LIN_SYNC_CHAR  = 10'h2AA;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_BREAK   = 3'd4,
    ST_DELIM   = 3'd5,
    ST_WAIT_HI = 3'd6
  } lin_state_t;

  // Pack a received byte with a good stop bit into the 10-bit character format.
  function automatic logic [9:0] lin_char(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

endpackage

// File: rtl/lin_rx_char_deframer_if.sv
// Deframer signal bundle. rx_in/en flow into the deframer; the rest flow out.
// Output semantics: char_valid is a one-cycle strobe meaning data_out changed
// this cycle (there is no back-pressure, the consumer must take it then);
// break_det only ever pulses together with char_valid; framing_err is a
// one-cycle strobe never coincident with char_valid; bus_idle is a level.
interface lin_rx_char_deframer_if;
  import lin_rx_char_deframer_pkg::*;

  logic       rx_in;
  logic       en;
  logic [9:0] data_out;
  logic       char_valid;
  logic       break_det;
  logic       framing_err;
  logic       bus_idle;
  lin_state_t dbg_state;

  modport master (
    output rx_in, en,
    input  data_out, char_valid, break_det, framing_err, bus_idle, dbg_state
  );

  modport slave (
    input  rx_in, en,
    output data_out, char_valid, break_det, framing_err, bus_idle, dbg_state
  );
endinterface

// File: rtl/lin_bit_sampler.sv
// LIN RX front end: synchroniser, falling-edge detect, bit-phase counter and
// 3-point majority sampling around the middle of each bit.
module lin_bit_sampler #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_rx,
  input  logic i_clr,
  output logic o_rx,
  output logic o_fall,
  output logic o_bit_tick,
  output logic o_bit_end,
  output logic o_sample
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] MID_M1 = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0] MID_P1 = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_rx_d;
  logic [CW-1:0] r_bit_cnt;
  logic          r_smp_a;
  logic          r_smp_b;

  // Two-flop synchroniser plus one delayed copy for edge detection; idle line is recessive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // Bit-phase counter; the deframer restarts it on a start edge so mid-bit lines up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
    end else if (i_clr || (r_bit_cnt == LAST)) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Capture the two early majority samples; the third is the live value at decision time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_smp_a <= 1'b1;
      r_smp_b <= 1'b1;
    end else begin
      if (r_bit_cnt == MID_M1) r_smp_a <= r_sync2;
      if (r_bit_cnt == MID)    r_smp_b <= r_sync2;
    end
  end

  assign o_rx       = r_sync2;
  assign o_fall     = r_rx_d & ~r_sync2;
  assign o_bit_tick = (r_bit_cnt == MID_P1);
  assign o_bit_end  = (r_bit_cnt == LAST);
  assign o_sample   = (r_smp_a & r_smp_b) | (r_smp_a & r_sync2) | (r_smp_b & r_sync2);

endmodule

// File: rtl/lin_rx_char_deframer.sv
// LIN slave receive deframer: rebuilds {stop, data, start} characters and
// recognises break, break delimiter and bus idle from the oversampled RX line.
module lin_rx_char_deframer
  import lin_rx_char_deframer_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 16,
  parameter int BREAK_MIN_BITS = 13,
  parameter int IDLE_BITS      = 40
) (
  input logic clk,
  input logic reset,
  lin_rx_char_deframer_if.slave dfr_if
);
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_BITS);
  localparam logic [7:0]    BRK_MIN  = 8'(BREAK_MIN_BITS);

  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_bit_end;
  logic w_sample;
  logic w_clr;

  lin_state_t    r_state;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_brk_cnt;
  logic [IW-1:0] r_idle_cnt;
  logic [9:0]    r_data_out;
  logic          r_char_valid;
  logic          r_break_det;
  logic          r_framing_err;

  lin_state_t    w_state_nxt;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    w_brk_cnt_nxt;
  logic [IW-1:0] w_idle_cnt_nxt;
  logic [9:0]    w_data_nxt;
  logic          w_cv_nxt;
  logic          w_bd_nxt;
  logic          w_fe_nxt;

  lin_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .i_rx      (dfr_if.rx_in),
    .i_clr     (w_clr),
    .o_rx      (w_rx),
    .o_fall    (w_fall),
    .o_bit_tick(w_tick),
    .o_bit_end (w_bit_end),
    .o_sample  (w_sample)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_brk_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_data_out    <= LIN_BREAK_CHAR;
      r_char_valid  <= 1'b0;
      r_break_det   <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_idx     <= w_bit_idx_nxt;
      r_shift       <= w_shift_nxt;
      r_brk_cnt     <= w_brk_cnt_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_data_out    <= w_data_nxt;
      r_char_valid  <= w_cv_nxt;
      r_break_det   <= w_bd_nxt;
      r_framing_err <= w_fe_nxt;
    end
  end

  // Next-state logic: frame walk, break/delimiter recognition and idle counting
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_brk_cnt_nxt  = r_brk_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    w_data_nxt     = r_data_out;
    w_cv_nxt       = 1'b0;
    w_bd_nxt       = 1'b0;
    w_fe_nxt       = 1'b0;
    w_clr          = 1'b0;

    if (!dfr_if.en) begin
      w_state_nxt    = ST_IDLE;
      w_idle_cnt_nxt = '0;
      w_clr          = 1'b1;
    end else begin
      if (w_fall) w_idle_cnt_nxt = '0;

      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            w_state_nxt = ST_START;
            w_clr       = 1'b1;
          end else if (w_tick && w_sample && (r_idle_cnt != IDLE_MAX)) begin
            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
          end
        end

        ST_START: begin
          if (w_tick) begin
            if (w_sample) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt   = ST_DATA;
              w_bit_idx_nxt = '0;
            end
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            w_shift_nxt = {w_sample, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            if (w_sample) begin
              w_data_nxt  = lin_char(r_shift);
              w_cv_nxt    = 1'b1;
              w_state_nxt = ST_IDLE;
            end else if (r_shift == 8'h00) begin
              // start + 8 data + stop were all dominant: ten break bits so far
              w_brk_cnt_nxt = 8'd10;
              w_state_nxt   = ST_BREAK;
            end else begin
              w_fe_nxt    = 1'b1;
              w_state_nxt = ST_WAIT_HI;
            end
          end
        end

        ST_BREAK: begin
          if (w_rx) begin
            if (r_brk_cnt >= BRK_MIN) begin
              w_data_nxt  = LIN_BREAK_CHAR;
              w_cv_nxt    = 1'b1;
              w_bd_nxt    = 1'b1;
              w_state_nxt = ST_DELIM;
              w_clr       = 1'b1;
            end else begin
              w_fe_nxt    = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else if (w_tick && !w_sample && (r_brk_cnt != 8'hFF)) begin
            w_brk_cnt_nxt = r_brk_cnt + 8'd1;
          end
        end

        ST_DELIM: begin
          if (w_fall) begin
            // delimiter too short; the edge is treated as the next start bit
            w_fe_nxt    = 1'b1;
            w_state_nxt = ST_START;
            w_clr       = 1'b1;
          end else if (w_bit_end) begin
            w_data_nxt  = LIN_DELIM_CHAR;
            w_cv_nxt    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end

        ST_WAIT_HI: begin
          if (w_rx) w_state_nxt = ST_IDLE;
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign dfr_if.data_out    = r_data_out;
  assign dfr_if.char_valid  = r_char_valid;
  assign dfr_if.break_det   = r_break_det;
  assign dfr_if.framing_err = r_framing_err;
  // Drops in the same cycle as a falling edge or enable removal
  assign dfr_if.bus_idle    = (r_idle_cnt == IDLE_MAX) & dfr_if.en & ~w_fall;
  assign dfr_if.dbg_state   = r_state;

endmodule

// File: tb/tb_lin_rx_char_deframer.sv
// Self-checking bench for the LIN RX character deframer.
module tb_lin_rx_char_deframer;
  import lin_rx_char_deframer_pkg::*;

  localparam int CPB = 16;

  logic clk;
  logic reset;

  lin_rx_char_deframer_if dif();

  lin_rx_char_deframer #(
    .CLKS_PER_BIT  (CPB),
    .BREAK_MIN_BITS(13),
    .IDLE_BITS     (40)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dfr_if(dif.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];   // {expected break_det, expected char}
  logic [9:0]  last_char;
  int          n_checks;
  int          n_err;
  int          fe_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic bd, input logic [9:0] ch);
    exp_q.push_back({bd, ch});
    last_char = ch;
  endtask

  logic [10:0] mon_e;
  always @(negedge clk) begin
    if (dif.char_valid) begin
      check("cv_fe_exclusive", 32'(dif.framing_err), 32'd0);
      if (exp_q.size() == 0) begin
        check("pending_chars", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("char", 32'(dif.data_out), 32'(mon_e[9:0]));
        check("break_det", 32'(dif.break_det), 32'(mon_e[10]));
      end
    end else if (dif.break_det) begin
      check("bd_with_cv", 32'(dif.char_valid), 32'd1);
    end
    if (dif.framing_err) fe_cnt++;
  end

  // ---------------- drivers ----------------
  task automatic drive_bits(input logic b, input int clks);
    dif.rx_in = b;
    repeat (clks) @(negedge clk);
  endtask

  // Start bit (possibly shortened when the edge was already driven), 8 data LSB first, stop
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit push, input int start_clks);
    if (push) push_exp(1'b0, {1'b1, d, 1'b0});
    drive_bits(1'b0, start_clks);
    for (int i = 0; i < 8; i++) drive_bits(d[i], CPB);
    drive_bits(stop, CPB);
  endtask

  // Same frame with a one-clock inverted spike in the middle of every bit
  task automatic send_frame_spiky(input logic [7:0] d);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    push_exp(1'b0, bits);
    for (int i = 0; i < 10; i++) begin
      drive_bits(bits[i], 8);
      drive_bits(~bits[i], 1);
      drive_bits(bits[i], CPB - 9);
    end
  endtask

  task automatic expect_drained(input string tag, input int fe_start, input int fe_exp);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_fe"}, 32'(fe_cnt - fe_start), 32'(fe_exp));
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  int fe0;
  initial begin
    n_checks  = 0;
    n_err     = 0;
    fe_cnt    = 0;
    last_char = 10'h000;
    reset     = 1'b0;
    dif.rx_in = 1'b1;
    dif.en    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(dif.data_out), 32'h000);
    check("rst_cv", 32'(dif.char_valid), 32'd0);
    check("rst_bd", 32'(dif.break_det), 32'd0);
    check("rst_fe", 32'(dif.framing_err), 32'd0);
    check("rst_bus_idle", 32'(dif.bus_idle), 32'd0);
    check("rst_state", 32'(dif.dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    drive_bits(1'b1, 2 * CPB);

    // 1: plain sync byte
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b1, 1'b1, CPB);
    drive_bits(1'b1, 2 * CPB);
    check("t1_data_out", 32'(dif.data_out), 32'h2AA);
    expect_drained("t1", fe0, 0);

    // 2: break 14, delimiter 2, sync, PID
    fe0 = fe_cnt;
    push_exp(1'b1, 10'h000);
    push_exp(1'b0, 10'h200);
    drive_bits(1'b0, 14 * CPB);
    drive_bits(1'b1, 2 * CPB);
    send_frame(8'h55, 1'b1, 1'b1, CPB);
    send_frame(8'h25, 1'b1, 1'b1, CPB);
    drive_bits(1'b1, 2 * CPB);
    expect_drained("t2", fe0, 0);

    // shortest accepted break
    fe0 = fe_cnt;
    push_exp(1'b1, 10'h000);
    push_exp(1'b0, 10'h200);
    drive_bits(1'b0, 13 * CPB);
    drive_bits(1'b1, 2 * CPB);
    expect_drained("brk13", fe0, 0);

    // 3: short breaks (11 and 12 bits) are framing errors
    fe0 = fe_cnt;
    drive_bits(1'b0, 11 * CPB);
    drive_bits(1'b1, 2 * CPB);
    check("t3_state", 32'(dif.dbg_state), 32'(ST_IDLE));
    drive_bits(1'b0, 12 * CPB);
    drive_bits(1'b1, 2 * CPB);
    expect_drained("t3", fe0, 2);

    // 4: bad stop bit keeps data_out
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, 1'b0, CPB);
    drive_bits(1'b1, 2 * CPB);
    check("t4_data_hold", 32'(dif.data_out), 32'(last_char));
    check("t4_state", 32'(dif.dbg_state), 32'(ST_IDLE));
    expect_drained("t4", fe0, 1);

    // short delimiter: error, and its falling edge starts the next byte
    fe0 = fe_cnt;
    push_exp(1'b1, 10'h000);
    drive_bits(1'b0, 14 * CPB);
    drive_bits(1'b1, CPB / 2);
    send_frame(8'h55, 1'b1, 1'b1, CPB);
    drive_bits(1'b1, 2 * CPB);
    expect_drained("shortdelim", fe0, 1);

    // 5: glitches rejected, majority sampling, bus idle
    fe0 = fe_cnt;
    drive_bits(1'b0, 1);
    drive_bits(1'b1, 2 * CPB);
    drive_bits(1'b0, 3);
    drive_bits(1'b1, 2 * CPB);
    expect_drained("t5_glitch", fe0, 0);
    fe0 = fe_cnt;
    send_frame_spiky(8'h55);
    drive_bits(1'b1, 38 * CPB);
    check("t5_idle_early", 32'(dif.bus_idle), 32'd0);
    drive_bits(1'b1, 4 * CPB);
    check("t5_idle_set", 32'(dif.bus_idle), 32'd1);
    dif.rx_in = 1'b0;
    @(negedge clk);
    check("t5_idle_before_edge", 32'(dif.bus_idle), 32'd1);
    @(negedge clk);
    check("t5_idle_clr_edge", 32'(dif.bus_idle), 32'd0);
    send_frame(8'hB4, 1'b1, 1'b1, CPB - 2);
    drive_bits(1'b1, 2 * CPB);
    expect_drained("t5", fe0, 0);

    // en=0 clears bus_idle at once
    drive_bits(1'b1, 42 * CPB);
    check("t6_idle_pre_en", 32'(dif.bus_idle), 32'd1);
    dif.en = 1'b0;
    #1;
    check("t6_idle_clr_en", 32'(dif.bus_idle), 32'd0);
    drive_bits(1'b1, CPB);
    dif.en = 1'b1;
    drive_bits(1'b1, 2 * CPB);

    // 6a: reset mid-DATA
    fe0 = fe_cnt;
    drive_bits(1'b0, CPB);
    drive_bits(1'b1, CPB);
    drive_bits(1'b0, CPB);
    drive_bits(1'b1, CPB / 2);
    check("t6a_in_data", 32'(dif.dbg_state), 32'(ST_DATA));
    reset     = 1'b0;
    dif.rx_in = 1'b1;
    @(negedge clk);
    last_char = 10'h000;
    check("t6a_rst_data", 32'(dif.data_out), 32'h000);
    check("t6a_rst_state", 32'(dif.dbg_state), 32'(ST_IDLE));
    check("t6a_rst_cv", 32'(dif.char_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    drive_bits(1'b1, 2 * CPB);
    send_frame(8'hC6, 1'b1, 1'b1, CPB);
    drive_bits(1'b1, 2 * CPB);
    expect_drained("t6a", fe0, 0);

    // 6b: en=0 mid-DATA
    fe0 = fe_cnt;
    drive_bits(1'b0, CPB);
    drive_bits(1'b0, CPB);
    drive_bits(1'b1, CPB);
    drive_bits(1'b1, CPB / 2);
    check("t6b_in_data", 32'(dif.dbg_state), 32'(ST_DATA));
    dif.en = 1'b0;
    drive_bits(1'b0, CPB);
    check("t6b_state", 32'(dif.dbg_state), 32'(ST_IDLE));
    check("t6b_data_hold", 32'(dif.data_out), 32'(last_char));
    check("t6b_bus_idle", 32'(dif.bus_idle), 32'd0);
    drive_bits(1'b1, 2 * CPB);
    dif.en = 1'b1;
    drive_bits(1'b1, CPB);
    send_frame(8'h3C, 1'b1, 1'b1, CPB);
    drive_bits(1'b1, 2 * CPB);
    check("t6b_data_out", 32'(dif.data_out), 32'h278);
    expect_drained("t6b", fe0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
